alu_req_arbiter: RTL

- Shares one combinational 8-bit ALU instance (opcodes 0..9: ADD, SUB, AND, OR, XNOR, SGT, MIN, ROR, SNE, PASSB; carry flag) between NREQ requesters.
- Round-robin selects a requester and registers its operands into the ALU inputs.
- Captures result/carry one cycle later and returns a tagged response through a valid/ready handshake.
- Sits between requesting engines and the generated ALU; the ALU itself is instantiated outside this block.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/rr_pick.sv | 36 +++
 rtl/alu_req_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, field widths, arbiter state
// encoding and the carry-producing opcode test.
package alu_pkg;

  localparam int ALU_OP_W    = 4;
  localparam int ALU_SHIFT_W = 5;

  localparam logic [ALU_OP_W-1:0] ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] AND   = 4'd2;
  localparam logic [ALU_OP_W-1:0] OR    = 4'd3;
  localparam logic [ALU_OP_W-1:0] XNOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] SGT   = 4'd5;
  localparam logic [ALU_OP_W-1:0] MIN   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ROR   = 4'd7;
  localparam logic [ALU_OP_W-1:0] SNE   = 4'd8;
  localparam logic [ALU_OP_W-1:0] PASSB = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic is_carry_op(input logic [ALU_OP_W-1:0] opcode);
    return (opcode == ADD) || (opcode == SUB);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr,
// wrapping modulo N. Outputs a one-hot grant, its index and an any flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Upper pass covers [ptr, N-1]; the lower pass only fires when that is
  // empty and then yields the lowest valid index, i.e. the wrapped search.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && valid[i] && (IW'(i) >= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && valid[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one external ALU between NREQ requesters.
// Define ALU_ARB_OVERLAP_EN to re-grant straight from RESP on response accept.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int IDW    = 2,
  parameter int MAX_OP = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [ALU_OP_W*NREQ-1:0]    req_opcode,
  input  logic [WIDTH*NREQ-1:0]       req_a,
  input  logic [WIDTH*NREQ-1:0]       req_b,
  input  logic [ALU_SHIFT_W*NREQ-1:0] req_shift,
  output logic [ALU_OP_W-1:0]         alu_opcode,
  output logic [WIDTH-1:0]            alu_in1,
  output logic [WIDTH-1:0]            alu_in2,
  output logic [ALU_SHIFT_W-1:0]      alu_shift,
  input  logic [WIDTH-1:0]            alu_result,
  input  logic                        alu_carry,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_data,
  output logic                        rsp_carry,
  output logic                        rsp_err,
  output logic [IDW-1:0]              rsp_id,
  output logic                        busy
);

  arb_state_e             state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [ALU_OP_W-1:0]    alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0]       alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0]       alu_in2_q, alu_in2_d;
  logic [ALU_SHIFT_W-1:0] alu_shift_q, alu_shift_d;
  logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic                   rsp_carry_q, rsp_carry_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [IDW-1:0]  id_inc;
  logic [IDW-1:0]  pick_ptr;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            grant_en;
  logic            illegal_op;

  always_comb begin
    id_inc = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
`ifdef ALU_ARB_OVERLAP_EN
    // In RESP the search starts from the pointer value being committed now.
    pick_ptr = (state_q == RESP) ? id_inc : rr_ptr_q;
`else
    pick_ptr = rr_ptr_q;
`endif
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    illegal_op   = (alu_opcode_q > ALU_OP_W'(MAX_OP));
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    alu_opcode_d = alu_opcode_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_shift_d  = alu_shift_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    grant_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) grant_en = 1'b1;
      end
      EXEC: begin
        rsp_err_d   = illegal_op;
        rsp_data_d  = illegal_op ? '0 : alu_result;
        rsp_carry_d = !illegal_op && is_carry_op(alu_opcode_q) && alu_carry;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = id_inc;
          state_d  = IDLE;
`ifdef ALU_ARB_OVERLAP_EN
          if (pick_any) grant_en = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_en) begin
      state_d = EXEC;
      id_d    = pick_idx;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (pick_grant[i]) begin
          alu_opcode_d = req_opcode[i*ALU_OP_W +: ALU_OP_W];
          alu_in1_d    = req_a[i*WIDTH +: WIDTH];
          alu_in2_d    = req_b[i*WIDTH +: WIDTH];
          alu_shift_d  = req_shift[i*ALU_SHIFT_W +: ALU_SHIFT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      alu_opcode_q <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_shift_q  <= '0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      alu_opcode_q <= alu_opcode_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_shift_q  <= alu_shift_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = (grant_en && !rst) ? pick_grant : '0;
  assign alu_opcode = alu_opcode_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_shift  = alu_shift_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_id     = id_q;
  assign busy       = (state_q != IDLE);

endmodule
